deconv_weight_fifo: RTL

DECONV_WEIGHT_FIFO -- requirements
Module: deconv_weight_fifo

---
 rtl/deconv_weight_fifo.sv | 134 +++++++++++++
 1 files changed

// File: rtl/deconv_weight_fifo.sv
// Weight staging buffer for the deconvolution cores: loads one W x W kernel set for
// four kernels from the BRAM reader, then exports it one column at a time on request.
module deconv_weight_fifo #(
  parameter int PIX_WIDTH                  = 16,
  parameter int SIZE_OF_WEIGHT             = 3,
  parameter int NUM_OF_CHANNEL_EACH_KERNEL = 4
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  output logic                                  weight_reader_en,
  input  logic                                  weight_reader_valid,
  input  logic [PIX_WIDTH-1:0]                  weight_reader_data_out,
  input  logic [3:0]                            weight_fifo_rd_en,
  input  logic [3:0]                            weight_fifo_loop,
  input  logic [3:0]                            weight_fifo_flush,
  output logic [PIX_WIDTH*SIZE_OF_WEIGHT*4-1:0] weight_fifo_out,
  output logic                                  weight_fifo_export_done,
  output logic                                  weight_fifo_core_init,
  output logic [1:0]                            fsm_state
);

  localparam int W       = SIZE_OF_WEIGHT;
  localparam int C       = NUM_OF_CHANNEL_EACH_KERNEL;
  localparam int COL_PIX = 4 * W;
  localparam int SET_PIX = 4 * W * W;
  localparam int COL_W   = PIX_WIDTH * COL_PIX;
  localparam int LDW     = $clog2(SET_PIX);
  localparam int OFFW    = (COL_PIX > 1) ? $clog2(COL_PIX) : 1;
  localparam int COLW    = (W > 1) ? $clog2(W) : 1;
  localparam int PTRW    = $clog2(W + 1);
  localparam int CHW     = $clog2(C + 1);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    READY = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [COL_W-1:0] col_mem [W];
  logic [LDW-1:0]   ld_cnt;
  logic [OFFW-1:0]  ld_off;
  logic [COLW-1:0]  ld_col;
  logic [PTRW-1:0]  rd_ptr;
  logic [CHW-1:0]   chan_cnt;

  logic            capture;
  logic            last_pix;
  logic            rd_req;
  logic            loop_req;
  logic            flush_req;
  logic            last_chan;
  logic            do_export;
  logic [PTRW-1:0] eff_ptr;

  // Reader enable is gated by reset so no pixel is requested while reset is held.
  assign weight_reader_en = (state == LOAD) && !i_rst;
  assign capture          = weight_reader_en && weight_reader_valid;
  assign last_pix         = (ld_cnt == LDW'(SET_PIX - 1));
  assign rd_req           = |weight_fifo_rd_en;
  assign loop_req         = |weight_fifo_loop;
  assign flush_req        = |weight_fifo_flush;
  assign last_chan        = (chan_cnt == CHW'(C - 1));
  // A loop in the same cycle as a read rewinds first, so column 0 is exported.
  assign eff_ptr          = loop_req ? '0 : rd_ptr;
  assign do_export        = (state == READY) && !flush_req && rd_req && (eff_ptr < PTRW'(W));
  assign fsm_state        = state;

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= LOAD;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      LOAD:    if (capture && last_pix) state_next = READY;
      READY:   if (flush_req) state_next = last_chan ? DONE : LOAD;
      DONE:    state_next = DONE;
      default: state_next = LOAD;
    endcase
  end

  // Pixel (c,k,r) arrives in column-major order, so the in-column offset k*W+r is just a running count.
  always_ff @(posedge i_clk) begin
    if (capture) col_mem[ld_col][int'(ld_off)*PIX_WIDTH +: PIX_WIDTH] <= weight_reader_data_out;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ld_cnt                  <= '0;
      ld_off                  <= '0;
      ld_col                  <= '0;
      rd_ptr                  <= '0;
      chan_cnt                <= '0;
      weight_fifo_out         <= '0;
      weight_fifo_export_done <= 1'b0;
      weight_fifo_core_init   <= 1'b0;
    end else begin
      weight_fifo_export_done <= do_export;
      weight_fifo_core_init   <= capture && last_pix;

      if (capture) begin
        if (last_pix) begin
          rd_ptr <= '0;
        end else begin
          ld_cnt <= ld_cnt + LDW'(1);
          if (ld_off == OFFW'(COL_PIX - 1)) begin
            ld_off <= '0;
            ld_col <= ld_col + COLW'(1);
          end else begin
            ld_off <= ld_off + OFFW'(1);
          end
        end
      end

      if (state == READY) begin
        if (flush_req) begin
          chan_cnt <= chan_cnt + CHW'(1);
          ld_cnt   <= '0;
          ld_off   <= '0;
          ld_col   <= '0;
        end else if (do_export) begin
          weight_fifo_out <= col_mem[eff_ptr[COLW-1:0]];
          rd_ptr          <= eff_ptr + PTRW'(1);
        end else if (loop_req) begin
          rd_ptr <= '0;
        end
      end
    end
  end

endmodule
